// File: rtl/dram_responder_pkg.sv
// Shared types and constants for the DRAM responder slice: clear-sequencer
// state encodings and the width of the optional access counters.
package dram_responder_pkg;

  typedef enum logic {
    DRAM_IDLE  = 1'b0,
    DRAM_CLEAR = 1'b1
  } dram_state_t;

  localparam int STATS_W = 16;

endpackage

// File: rtl/dram_responder_if.sv
// Host loader port of the DRAM responder: valid/ready request channel plus
// a one-cycle read-data return pulse.
interface dram_responder_if #(parameter int WIDTH = 8);

  logic             host_valid;
  logic             host_ready;
  logic             host_we;
  logic [WIDTH-1:0] host_addr;
  logic [WIDTH-1:0] host_wdata;
  logic [WIDTH-1:0] host_rdata;
  logic             host_rvalid;

  modport master (
    output host_valid, host_we, host_addr, host_wdata,
    input  host_ready, host_rdata, host_rvalid
  );

  modport slave (
    input  host_valid, host_we, host_addr, host_wdata,
    output host_ready, host_rdata, host_rvalid
  );

endinterface

// File: rtl/dram_responder_array.sv
// Single-write-port RAM with a registered core read and a combinational
// read used for host capture. Write priority is core > clear > host.
module dram_array #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             core_we,
  input  logic             core_re,
  input  logic [WIDTH-1:0] core_addr,
  input  logic [WIDTH-1:0] core_wdata,
  input  logic             clr_we,
  input  logic [WIDTH-1:0] clr_addr,
  input  logic             host_we,
  input  logic [WIDTH-1:0] host_addr,
  input  logic [WIDTH-1:0] host_wdata,
  output logic [WIDTH-1:0] core_rdata,
  output logic [WIDTH-1:0] host_rdata_comb
);

  localparam int DEPTH = 2**WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic [WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;

  always_comb begin
    wr_en   = 1'b1;
    wr_addr = core_addr;
    wr_data = core_wdata;
    if (core_we) begin
      wr_addr = core_addr;
      wr_data = core_wdata;
    end else if (clr_we) begin
      wr_addr = clr_addr;
      wr_data = '0;
    end else if (host_we) begin
      wr_addr = host_addr;
      wr_data = host_wdata;
    end else begin
      wr_en = 1'b0;
    end
  end

  // Storage has no reset: contents survive a reset, including a partial clear.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       core_rdata <= '0;
    else if (core_re) core_rdata <= mem[core_addr];
  end

  assign host_rdata_comb = mem[host_addr];

endmodule

// File: rtl/dram_responder.sv
// Zero-wait-state DRAM responder for the core, with a host loader port and a
// whole-array clear sequencer. Define DRAM_STATS_EN to add rd_count/wr_count.
module dram_responder
  import dram_responder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             memREAD,
  input  logic             memWRITE,
  input  logic [WIDTH-1:0] DRAM_addr,
  input  logic [WIDTH-1:0] DRAM_dataOut,
  output logic [WIDTH-1:0] DRAM_dataIn,
  dram_responder_if.slave  host,
  input  logic             clr_start,
  output logic             clr_busy,
  output logic             clr_done,
  output logic             err
`ifdef DRAM_STATS_EN
  ,
  output logic [STATS_W-1:0] rd_count,
  output logic [STATS_W-1:0] wr_count
`endif
);

  dram_state_t      state;
  dram_state_t      state_nxt;
  logic [WIDTH-1:0] idx;
  logic             core_busy;
  logic             clr_we;
  logic             host_accept;
  logic             host_wr;
  logic             host_rd;
  logic [WIDTH-1:0] host_rdata_comb;

  assign core_busy   = memREAD | memWRITE;
  assign host_accept = host.host_valid & host.host_ready;
  assign host_wr     = host_accept & host.host_we;
  assign host_rd     = host_accept & ~host.host_we;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= DRAM_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DRAM_IDLE:  if (clr_start) state_nxt = DRAM_CLEAR;
      DRAM_CLEAR: if (!core_busy && idx == '1) state_nxt = DRAM_IDLE;
      default:    state_nxt = DRAM_IDLE;
    endcase
  end

  // A core strobe pauses the clear; the host is locked out for the whole clear.
  always_comb begin
    clr_busy        = (state == DRAM_CLEAR);
    clr_we          = clr_busy & ~core_busy;
    host.host_ready = (state == DRAM_IDLE) & ~core_busy & ~host.host_rvalid;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      idx      <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= clr_we && (idx == '1);
      if (state == DRAM_IDLE && clr_start) idx <= '0;
      else if (clr_we)                     idx <= idx + WIDTH'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      host.host_rvalid <= 1'b0;
      host.host_rdata  <= '0;
      err              <= 1'b0;
    end else begin
      host.host_rvalid <= host_rd;
      if (host_rd) host.host_rdata <= host_rdata_comb;
      if (memREAD && memWRITE) err <= 1'b1;
    end
  end

`ifdef DRAM_STATS_EN
  // Both-strobe cycles count as writes only; counters stick at all-ones.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (memWRITE && wr_count != '1)
        wr_count <= wr_count + STATS_W'(1);
      if (memREAD && !memWRITE && rd_count != '1)
        rd_count <= rd_count + STATS_W'(1);
    end
  end
`endif

  dram_array #(.WIDTH(WIDTH)) u_array (
    .clk             (Clk),
    .rst_n           (Rst_n),
    .core_we         (memWRITE),
    .core_re         (memREAD & ~memWRITE),
    .core_addr       (DRAM_addr),
    .core_wdata      (DRAM_dataOut),
    .clr_we          (clr_we),
    .clr_addr        (idx),
    .host_we         (host_wr),
    .host_addr       (host.host_addr),
    .host_wdata      (host.host_wdata),
    .core_rdata      (DRAM_dataIn),
    .host_rdata_comb (host_rdata_comb)
  );

endmodule

// File: tb/tb_dram_responder.sv
// Directed plus randomized bench for dram_responder, checked against a plain
// array model of the memory and the handshake rules.
module tb_dram_responder;

  localparam int WIDTH = 8;
  localparam int DEPTH = 256;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       memREAD = 1'b0;
  logic       memWRITE = 1'b0;
  logic [7:0] DRAM_addr = '0;
  logic [7:0] DRAM_dataOut = '0;
  logic [7:0] DRAM_dataIn;
  logic       clr_start = 1'b0;
  logic       clr_busy;
  logic       clr_done;
  logic       err;
`ifdef DRAM_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  dram_responder_if #(.WIDTH(WIDTH)) hif ();

  dram_responder #(.WIDTH(WIDTH)) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .memREAD      (memREAD),
    .memWRITE     (memWRITE),
    .DRAM_addr    (DRAM_addr),
    .DRAM_dataOut (DRAM_dataOut),
    .DRAM_dataIn  (DRAM_dataIn),
    .host         (hif),
    .clr_start    (clr_start),
    .clr_busy     (clr_busy),
    .clr_done     (clr_done),
    .err          (err)
`ifdef DRAM_STATS_EN
    ,
    .rd_count     (rd_count),
    .wr_count     (wr_count)
`endif
  );

  always #5 Clk = ~Clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] model [DEPTH];
  logic [7:0] exp_din = '0;
  logic [7:0] exp_rdata = '0;
  logic       exp_rvalid = 1'b0;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    memREAD      = rd;
    memWRITE     = wr;
    DRAM_addr    = a;
    DRAM_dataOut = d;
  endtask

  task automatic coreRead(input logic [7:0] a, input string tag);
    applyStimulus(1'b1, 1'b0, a, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    exp_din = model[a];
    checkOutput(tag, DRAM_dataIn, exp_din);
  endtask

  task automatic hostXfer(input logic we, input logic [7:0] a, input logic [7:0] d, input string tag);
    int n;
    hif.host_valid = 1'b1;
    hif.host_we    = we;
    hif.host_addr  = a;
    hif.host_wdata = d;
    #1;
    n = 0;
    while (!hif.host_ready && n < 10) begin
      tick();
      n++;
    end
    if (n >= 10) checkOutput("host_ready_timeout", hif.host_ready, 1);
    tick();
    hif.host_valid = 1'b0;
    if (we) begin
      model[a] = d;
    end else begin
      exp_rdata = model[a];
      checkOutput({tag, "_rvalid"}, hif.host_rvalid, 1);
      checkOutput({tag, "_rdata"}, hif.host_rdata, exp_rdata);
    end
  endtask

  initial begin
    int         busy_cyc;
    int         done_cnt;
    int         n;
    int         cidx;
    int         op;
    logic       pend;
    logic       p_we;
    logic [7:0] p_a;
    logic [7:0] p_d;
    logic       exp_ready;
    logic       nxt_rvalid;
    logic       inj;

    hif.host_valid = 1'b0;
    hif.host_we    = 1'b0;
    hif.host_addr  = '0;
    hif.host_wdata = '0;

    // Reset values
    repeat (3) tick();
    checkOutput("rst_dataIn", DRAM_dataIn, 0);
    checkOutput("rst_host_rdata", hif.host_rdata, 0);
    checkOutput("rst_host_rvalid", hif.host_rvalid, 0);
    checkOutput("rst_clr_busy", clr_busy, 0);
    checkOutput("rst_clr_done", clr_done, 0);
    checkOutput("rst_err", err, 0);
    Rst_n = 1'b1;
    tick();
    checkOutput("rst_host_ready", hif.host_ready, 1);

    // Clear with no core traffic
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    checkOutput("clr_host_ready_low", hif.host_ready, 0);
    busy_cyc = 0;
    done_cnt = 0;
    n = 0;
    while (clr_busy && n < 600) begin
      busy_cyc++;
      if (clr_done) done_cnt++;
      tick();
      n++;
    end
    checkOutput("clr_busy_cycles", busy_cyc, 256);
    checkOutput("clr_done_early", done_cnt, 0);
    checkOutput("clr_done_pulse", clr_done, 1);
    tick();
    checkOutput("clr_done_single", clr_done, 0);
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    for (int i = 0; i < DEPTH; i++) hostXfer(1'b0, 8'(i), 8'h00, "clr_zero");

    // Host write then core read
    hostXfer(1'b1, 8'h05, 8'h11, "hw05");
    coreRead(8'h05, "core_rd_05");

    // Core write blocks host in the same cycle
    tick();
    applyStimulus(1'b0, 1'b1, 8'h20, 8'hA5);
    hif.host_valid = 1'b1;
    hif.host_we    = 1'b1;
    hif.host_addr  = 8'h21;
    hif.host_wdata = 8'h6E;
    #1;
    checkOutput("ready_blocked_by_core", hif.host_ready, 0);
    tick();
    model[8'h20] = 8'hA5;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    checkOutput("ready_after_core", hif.host_ready, 1);
    tick();
    hif.host_valid = 1'b0;
    model[8'h21] = 8'h6E;
    hostXfer(1'b0, 8'h20, 8'h00, "hr20");
    hostXfer(1'b0, 8'h21, 8'h00, "hr21");
    tick();

    // Randomized core/host traffic
    exp_rvalid = 1'b0;
    pend = 1'b0;
    p_we = 1'b0;
    p_a = '0;
    p_d = '0;
    for (int c = 0; c < 300; c++) begin
      op = $urandom_range(0, 3);
      applyStimulus(op == 1, op == 2, 8'($urandom_range(0, 15)), 8'($urandom));
      if (!pend && $urandom_range(0, 1) == 1) begin
        pend = 1'b1;
        p_we = 1'($urandom_range(0, 1));
        p_a  = 8'($urandom_range(0, 15));
        p_d  = 8'($urandom);
      end
      hif.host_valid = pend;
      hif.host_we    = p_we;
      hif.host_addr  = p_a;
      hif.host_wdata = p_d;
      #1;
      exp_ready = !memREAD && !memWRITE && !exp_rvalid;
      checkOutput("rand_host_ready", hif.host_ready, exp_ready);
      if (memWRITE) model[DRAM_addr] = DRAM_dataOut;
      if (memREAD) exp_din = model[DRAM_addr];
      nxt_rvalid = 1'b0;
      if (pend && exp_ready) begin
        pend = 1'b0;
        if (p_we) model[p_a] = p_d;
        else begin
          exp_rdata  = model[p_a];
          nxt_rvalid = 1'b1;
        end
      end
      exp_rvalid = nxt_rvalid;
      tick();
      checkOutput("rand_dataIn", DRAM_dataIn, exp_din);
      checkOutput("rand_rvalid", hif.host_rvalid, exp_rvalid);
      checkOutput("rand_rdata", hif.host_rdata, exp_rdata);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    hif.host_valid = 1'b0;
    tick();
    tick();

    // Clear with three core reads injected
    hostXfer(1'b1, 8'h03, 8'h99, "pre_clr03");
    hostXfer(1'b1, 8'hC8, 8'h77, "pre_clrC8");
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    busy_cyc = 0;
    cidx = 0;
    n = 0;
    while (clr_busy && n < 700) begin
      busy_cyc++;
      inj = (busy_cyc == 3) || (busy_cyc == 13) || (busy_cyc == 161);
      if (busy_cyc == 3)        applyStimulus(1'b1, 1'b0, 8'h03, 8'h00);
      else if (busy_cyc == 13)  applyStimulus(1'b1, 1'b0, 8'h05, 8'h00);
      else if (busy_cyc == 161) applyStimulus(1'b1, 1'b0, 8'hC8, 8'h00);
      if (inj) exp_din = model[DRAM_addr];
      else if (cidx < DEPTH) begin
        model[cidx] = 8'h00;
        cidx++;
      end
      tick();
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
      if (inj) checkOutput("clr_inject_read", DRAM_dataIn, exp_din);
      n++;
    end
    checkOutput("clr_inject_cycles", busy_cyc, 259);
    checkOutput("clr_inject_done", clr_done, 1);
    for (int i = 0; i < DEPTH; i++) coreRead(8'(i), "post_clr_sweep");

    // Both strobes: write wins, read suppressed, err sticky
    applyStimulus(1'b1, 1'b1, 8'h10, 8'h3C);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    model[8'h10] = 8'h3C;
    checkOutput("both_err", err, 1);
    checkOutput("both_dataIn_held", DRAM_dataIn, exp_din);
    tick();
    tick();
    checkOutput("err_sticky", err, 1);
    coreRead(8'h10, "both_mem10");

    // Reset in the middle of a clear
    hostXfer(1'b1, 8'h80, 8'h5A, "pre_rst80");
    hostXfer(1'b1, 8'h63, 8'h21, "pre_rst63");
    hostXfer(1'b0, 8'h80, 8'h00, "pre_rst_rd80");
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      model[i] = 8'h00;
      tick();
    end
    Rst_n = 1'b0;
    #1;
    checkOutput("midrst_dataIn", DRAM_dataIn, 0);
    checkOutput("midrst_host_rdata", hif.host_rdata, 0);
    checkOutput("midrst_rvalid", hif.host_rvalid, 0);
    checkOutput("midrst_busy", clr_busy, 0);
    checkOutput("midrst_done", clr_done, 0);
    checkOutput("midrst_err", err, 0);
    checkOutput("midrst_host_ready", hif.host_ready, 1);
    #2;
    Rst_n = 1'b1;
    exp_din = 8'h00;
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (clr_done || clr_busy) done_cnt++;
    end
    checkOutput("midrst_no_done", done_cnt, 0);
    coreRead(8'h80, "midrst_keep80");
    coreRead(8'h63, "midrst_zero63");
    coreRead(8'h64, "midrst_idx100");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
